// File: rtl/addr_dec_pkg.sv
// Shared types and constants for the wait-state address decoder.
// Used by addr_decoder_ws; macro ADDR_DEC_ERR_EN is handled in the top.
package addr_dec_pkg;

    localparam int WS_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam state_e STATE_RST = S_IDLE;

endpackage

// File: rtl/addr_range_match.sv
// Combinational inclusive bounds compare: hit when base <= addr <= limit (unsigned).
module addr_range_match #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] limit,
    output logic              hit
);

    assign hit = (addr >= base) && (addr <= limit);

endmodule

// File: rtl/addr_decoder_ws.sv
// Address decoder with per-region wait states and a registered chip-select.
// Define ADDR_DEC_ERR_EN to flag unmapped accesses with err instead of routing them to ext_cs.
module addr_decoder_ws
    import addr_dec_pkg::*;
#(
    parameter int                     ADDR_W = 32,
    parameter int                     NREG   = 2,
    parameter logic [NREG*ADDR_W-1:0] BASE   = {32'h0000_2000, 32'h0000_1730},
    parameter logic [NREG*ADDR_W-1:0] LIMIT  = {32'h0000_23FF, 32'h0000_1B2F},
    parameter logic [NREG*WS_W-1:0]   WS     = {4'd2, 4'd0},
    parameter logic [WS_W-1:0]        EXT_WS = 4'd3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic [NREG-1:0]   cs,
    output logic              ext_cs,
    output logic              busy,
    output logic              ready,
    output logic              err
);

    localparam logic [WS_W-1:0] WS_ONE = 1;

    state_e          state, state_nx;
    logic [WS_W-1:0] cnt;
    logic [NREG-1:0] hit;
    logic [NREG-1:0] dec_cs;
    logic [WS_W-1:0] dec_ws;
    logic            dec_ext;
    logic            dec_err;
    logic            any_hit;
    logic [NREG-1:0] cs_r;
    logic            ext_r;
    logic            err_r;

    for (genvar g = 0; g < NREG; g++) begin : g_rng
        addr_range_match #(
            .ADDR_W(ADDR_W)
        ) u_match (
            .addr (addr),
            .base (BASE[g*ADDR_W +: ADDR_W]),
            .limit(LIMIT[g*ADDR_W +: ADDR_W]),
            .hit  (hit[g])
        );
    end

    // Scan from the highest index down so the lowest matching region wins.
    always_comb begin
        dec_cs  = '0;
        dec_ws  = '0;
        any_hit = 1'b0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (hit[i]) begin
                dec_cs    = '0;
                dec_cs[i] = 1'b1;
                dec_ws    = WS[i*WS_W +: WS_W];
                any_hit   = 1'b1;
            end
        end
`ifdef ADDR_DEC_ERR_EN
        dec_ext = 1'b0;
        dec_err = !any_hit;
`else
        dec_ext = !any_hit;
        dec_err = 1'b0;
        if (!any_hit) begin
            dec_ws = EXT_WS;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STATE_RST;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (req) state_nx = (dec_ws == '0) ? S_DONE : S_WAIT;
            S_WAIT: if (cnt == WS_ONE) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Selects are latched on accept and dropped on the edge leaving DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            cs_r  <= '0;
            ext_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        cnt   <= dec_ws;
                        cs_r  <= dec_cs;
                        ext_r <= dec_ext;
                        err_r <= dec_err;
                    end
                end
                S_WAIT: cnt <= cnt - WS_ONE;
                default: begin
                    cnt   <= '0;
                    cs_r  <= '0;
                    ext_r <= 1'b0;
                    err_r <= 1'b0;
                end
            endcase
        end
    end

    assign cs     = cs_r;
    assign ext_cs = ext_r;
    assign busy   = (state != S_IDLE);
    assign ready  = (state == S_DONE);

`ifdef ADDR_DEC_ERR_EN
    assign err = err_r & ready;
`else
    assign err = 1'b0 & err_r;
`endif

endmodule

// File: tb/tb_addr_decoder_ws.sv
// Directed bench for addr_decoder_ws (default NREG=2 plus an overlapping NREG=3 instance).
// Follows ADDR_DEC_ERR_EN so the same file covers both builds.
module tb_addr_decoder_ws;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, req3;
    logic [31:0] addr, addr3;
    logic [1:0]  cs;
    logic [2:0]  cs3;
    logic        ext_cs, busy, ready, err;
    logic        ext_cs3, busy3, ready3, err3;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    addr_decoder_ws u_dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .addr  (addr),
        .cs    (cs),
        .ext_cs(ext_cs),
        .busy  (busy),
        .ready (ready),
        .err   (err)
    );

    // Region 2 overlaps region 0 across 0x1730..0x1900.
    addr_decoder_ws #(
        .NREG (3),
        .BASE ({32'h0000_1700, 32'h0000_2000, 32'h0000_1730}),
        .LIMIT({32'h0000_1900, 32'h0000_23FF, 32'h0000_1B2F}),
        .WS   ({4'd1, 4'd2, 4'd0})
    ) u_dut3 (
        .clk   (clk),
        .rst   (rst),
        .req   (req3),
        .addr  (addr3),
        .cs    (cs3),
        .ext_cs(ext_cs3),
        .busy  (busy3),
        .ready (ready3),
        .err   (err3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one access, then check every cycle up to and including ready, then idle.
    task automatic run_access(input string tag, input logic [31:0] a, input logic [1:0] ecs,
                              input logic eext, input logic eerr, input int lat, input bit poke);
        addr = a;
        req  = 1'b1;
        tick();
        req  = 1'b0;
        addr = $urandom;
        for (int k = 1; k <= lat; k++) begin
            if (poke && k == 1) begin
                req  = 1'b1;
                addr = 32'h0000_1730;
            end
            chk({tag, "_cs"}, 32'(cs), 32'(ecs));
            chk({tag, "_ext"}, 32'(ext_cs), 32'(eext));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_ready"}, 32'(ready), 32'(k == lat));
            if (k == lat) chk({tag, "_err"}, 32'(err), 32'(eerr));
            if (k < lat) begin
                tick();
                req = 1'b0;
            end
        end
        tick();
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_cs"}, 32'(cs), 32'd0);
        chk({tag, "_idle_ext"}, 32'(ext_cs), 32'd0);
        chk({tag, "_idle_ready"}, 32'(ready), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        req   = 1'b0;
        addr  = '0;
        req3  = 1'b0;
        addr3 = '0;
        tick();
        tick();
        chk("rst_cs", 32'(cs), 32'd0);
        chk("rst_ext", 32'(ext_cs), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();

        // Region 0 base, zero wait states.
        run_access("r0_base", 32'h0000_1730, 2'b01, 1'b0, 1'b0, 1, 1'b0);
        // Region 0 limit, then one past it (unmapped).
        run_access("r0_limit", 32'h0000_1B2F, 2'b01, 1'b0, 1'b0, 1, 1'b0);
`ifdef ADDR_DEC_ERR_EN
        run_access("r0_above", 32'h0000_1B30, 2'b00, 1'b0, 1'b1, 1, 1'b0);
`else
        run_access("r0_above", 32'h0000_1B30, 2'b00, 1'b1, 1'b0, 4, 1'b0);
`endif
        // Region 1 with two waits; a req pulse while busy must be ignored.
        run_access("r1_base", 32'h0000_2000, 2'b10, 1'b0, 1'b0, 3, 1'b1);
        run_access("r1_limit", 32'h0000_23FF, 2'b10, 1'b0, 1'b0, 3, 1'b0);
`ifdef ADDR_DEC_ERR_EN
        run_access("unmapped0", 32'h0000_0000, 2'b00, 1'b0, 1'b1, 1, 1'b0);
`else
        run_access("unmapped0", 32'h0000_0000, 2'b00, 1'b1, 1'b0, 4, 1'b0);
`endif

        // Reset in the middle of WAIT, with a simultaneous req that must be dropped.
        addr = 32'h0000_2000;
        req  = 1'b1;
        tick();
        req = 1'b0;
        chk("midwait_busy", 32'(busy), 32'd1);
        rst  = 1'b1;
        req  = 1'b1;
        addr = 32'h0000_1730;
        tick();
        rst = 1'b0;
        req = 1'b0;
        chk("midrst_cs", 32'(cs), 32'd0);
        chk("midrst_ext", 32'(ext_cs), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("midrst_noready", 32'(ready), 32'd0);
        end
        run_access("after_rst", 32'h0000_1730, 2'b01, 1'b0, 1'b0, 1, 1'b0);

        // Overlap: 0x1800 hits regions 0 and 2, region 0 wins.
        addr3 = 32'h0000_1800;
        req3  = 1'b1;
        tick();
        req3 = 1'b0;
        chk("ovl_cs", 32'(cs3), 32'b001);
        chk("ovl_ready", 32'(ready3), 32'd1);
        tick();
        chk("ovl_idle", 32'(busy3), 32'd0);
        // 0x1710 hits region 2 only (one wait state).
        addr3 = 32'h0000_1710;
        req3  = 1'b1;
        tick();
        req3 = 1'b0;
        chk("r2_cs", 32'(cs3), 32'b100);
        chk("r2_ready_early", 32'(ready3), 32'd0);
        tick();
        chk("r2_ready", 32'(ready3), 32'd1);
        chk("r2_cs_done", 32'(cs3), 32'b100);
        chk("r2_ext", 32'(ext_cs3), 32'd0);
        tick();
        chk("r2_idle", 32'(busy3), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addr_decoder_ws.md
ADDR_DECODER_WS -- requirements
Module: addr_decoder_ws

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter NREG, default 2: internal region count, 1..8.
REQ-003 SHALL have parameter BASE, default {32'h0000_2000, 32'h0000_1730}: packed NREG*ADDR_W region bases, with region 0 in the LSBs.
REQ-004 SHALL have parameter LIMIT, default {32'h0000_23FF, 32'h0000_1B2F}: packed inclusive region limits.
REQ-005 SHALL have parameter WS, default {4'd2, 4'd0}: packed NREG*4 wait states per region.
REQ-006 SHALL have parameter EXT_WS, default 4'd3: wait states for external (unmapped) accesses.
REQ-007 SHALL have one clock; reset is synchronous and active-high. Ports: clk input 1: rising-edge clock; rst input 1: synchronous active-high reset.
REQ-008 SHALL have port req, input, 1 bit: access request, sampled in IDLE only.
REQ-009 SHALL have port addr, input, ADDR_W bits: access address, sampled with req.
REQ-010 SHALL have port cs, output, NREG bits: registered one-hot internal chip select.
REQ-011 SHALL have port ext_cs, output, 1 bit: registered external-memory select.
REQ-012 SHALL have port busy, output, 1 bit: high while state is not IDLE.
REQ-013 SHALL have port ready, output, 1 bit: single-cycle completion pulse.
REQ-014 SHALL have port err, output, 1 bit: unmapped-access flag, valid only when ready is high.

Function
REQ-015 SHALL define a region hit as BASE[i] <= addr <= LIMIT[i], unsigned, with both bounds inclusive.
REQ-016 SHALL resolve overlapping regions by priority: the lowest index wins; cs SHALL never have more than one bit set.
REQ-017 SHALL implement states IDLE, WAIT and DONE.
REQ-018 SHALL, in IDLE with req=1 at an edge, latch the decode result, load the wait counter with the selected WS, and go to DONE if the count is 0, otherwise to WAIT.
REQ-019 SHALL, in WAIT, decrement the counter each cycle and go to DONE on the edge where the counter is 1.
REQ-020 SHALL, in DONE, assert ready for exactly one cycle and then return to IDLE.
REQ-021 SHALL give latency from the accept edge to the ready cycle of N+1 cycles for N wait states.
REQ-022 SHALL hold the selected cs/ext_cs from the accept edge through the DONE cycle inclusive, and deassert both in IDLE.
REQ-023 SHALL ignore req and addr while busy; a new request is accepted at the earliest one cycle after ready.
REQ-024 SHALL compute busy and ready from registered state only, with no combinational path from req or addr.

Reset
REQ-025 SHALL, with rst high at an edge, force IDLE, counter 0, and cs=0, ext_cs=0, busy=0, ready=0, err=0, including mid-WAIT or mid-DONE.
REQ-026 SHALL give rst priority over a simultaneous req, which is dropped.

Configuration
REQ-027 SHALL support macro ADDR_DEC_ERR_EN.
REQ-028 SHALL, when ADDR_DEC_ERR_EN is defined, treat an unmapped access as follows: no cs/ext_cs, zero wait states, and err=1 together with ready.
REQ-029 SHALL, when ADDR_DEC_ERR_EN is undefined, route an unmapped access to ext_cs with EXT_WS waits, and tie err to 0 (the port remains present).

Structure
REQ-030 SHALL place the state enum, WS_W=4, and the default IDLE constant in shared package addr_dec_pkg.
REQ-031 SHALL instantiate one sub-module, addr_range_match (combinational bounds compare), per region via generate.

Verification
REQ-032 SHALL verify: req, addr=32'h1730 -> cs=2'b01 the next cycle, ready one cycle after accept, err=0.
REQ-033 SHALL verify: req, addr=32'h1B2F, then 32'h1B30 -> first access hits cs[0]; second gives ext_cs=1 and ready 4 cycles after accept (ERR_EN off).
REQ-034 SHALL verify: req, addr=32'h2000 -> cs=2'b10 held 3 cycles, ready at accept+3; a req pulse during busy is ignored.
REQ-035 SHALL verify: ADDR_DEC_ERR_EN on, addr=32'h0000_0000 -> ready and err both high at accept+1, cs=0, ext_cs=0.
REQ-036 SHALL verify: rst asserted during WAIT of a 32'h2000 access -> all outputs 0 after the edge, no ready pulse, and the next req is accepted normally.
REQ-037 SHALL verify: NREG=3 with region 2 overlapping region 0 at 32'h1800 -> only cs[0] is asserted.
